// File: rtl/seg_display_arbiter_if.sv
// Requester-side bus of the seven-segment display arbiter: level requests,
// per-requester data words and decimal-point masks, and the one-hot grant.
interface seg_display_arbiter_if;
  logic [1:0]  i_req;
  logic [31:0] i_data0;
  logic [31:0] i_data1;
  logic [7:0]  i_dp0;
  logic [7:0]  i_dp1;
  logic [1:0]  o_grant;

  modport master (
    output i_req, i_data0, i_data1, i_dp0, i_dp1,
    input  o_grant
  );

  modport slave (
    input  i_req, i_data0, i_data1, i_dp0, i_dp1,
    output o_grant
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Scan controller and two-way arbiter for an 8-digit, active-low, multiplexed
// seven-segment display. Each frame starts with one arbitration cycle that
// latches a shadow copy of the grantee's word, then scans eight digit slots,
// each opening with a blanking interval to suppress ghosting.
module seg_display_arbiter #(
  parameter int unsigned CLK_DIV      = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned HOLD_FRAMES  = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  seg_display_arbiter_if.slave        bus,
  output logic [7:0]                  o_AN,
  output logic [6:0]                  o_A2G,
  output logic                        o_DP,
  output logic                        o_frame_done
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_FRAMES);

  typedef enum logic [1:0] {ST_ARB, ST_BLANK, ST_DRIVE} state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  digit_q, digit_d;
  logic [1:0]  grant_q, grant_d;
  logic [HW-1:0] hold_q, hold_d;
  logic        last_q, last_d;
  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  dps_q, dps_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  a2g_q, a2g_d;
  logic        dp_q, dp_d;
  logic        fd_q, fd_d;
  logic        cur_idx, cur_req, oth_req;

  // Active-low abcdefg patterns for hex digits 0-F.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  // Next-state, arbitration and registered-output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    digit_d  = digit_q;
    grant_d  = grant_q;
    hold_d   = hold_q;
    last_d   = last_q;
    shadow_d = shadow_q;
    dps_d    = dps_q;
    fd_d     = 1'b0;
    an_d     = '1;
    a2g_d    = '1;
    dp_d     = 1'b1;
    cur_idx  = grant_q[1];
    cur_req  = bus.i_req[grant_q[1]];
    oth_req  = bus.i_req[~grant_q[1]];

    unique case (state_q)
      ST_ARB: begin
        if (grant_q != '0) begin
          if (cur_req && (!oth_req || hold_q < HOLD_MAX)) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
          end else if (oth_req) begin
            // grant is one-hot, so inverting it hands over to the other side
            grant_d = ~grant_q;
            hold_d  = HW'(1);
          end else begin
            grant_d = '0;
            hold_d  = '0;
          end
        end else if (bus.i_req == 2'b11) begin
          grant_d = last_q ? 2'b01 : 2'b10;
          hold_d  = HW'(1);
        end else if (bus.i_req != '0) begin
          grant_d = bus.i_req;
          hold_d  = HW'(1);
        end else begin
          hold_d  = '0;
        end
        if (grant_d != '0) last_d = grant_d[1];
        shadow_d = grant_d[0] ? bus.i_data0 : (grant_d[1] ? bus.i_data1 : '0);
        dps_d    = grant_d[0] ? bus.i_dp0   : (grant_d[1] ? bus.i_dp1   : '0);
        digit_d  = '0;
        cnt_d    = '0;
        state_d  = ST_BLANK;
      end
      ST_BLANK: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == BLANK_LAST) state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (grant_q != '0) begin
          an_d  = ~(8'b1 << digit_q);
          a2g_d = hex7(shadow_q[{digit_q, 2'b00} +: 4]);
          dp_d  = ~dps_q[digit_q];
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (digit_q != 3'd7) begin
            digit_d = digit_q + 3'd1;
            state_d = ST_BLANK;
          end else begin
            fd_d    = 1'b1;
            state_d = ST_ARB;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_ARB;
      cnt_q    <= '0;
      digit_q  <= '0;
      grant_q  <= '0;
      hold_q   <= '0;
      last_q   <= 1'b1;
      shadow_q <= '0;
      dps_q    <= '0;
      an_q     <= '1;
      a2g_q    <= '1;
      dp_q     <= 1'b1;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digit_q  <= digit_d;
      grant_q  <= grant_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
      shadow_q <= shadow_d;
      dps_q    <= dps_d;
      an_q     <= an_d;
      a2g_q    <= a2g_d;
      dp_q     <= dp_d;
      fd_q     <= fd_d;
    end
  end

  assign bus.o_grant   = grant_q;
  assign o_AN          = an_q;
  assign o_A2G         = a2g_q;
  assign o_DP          = dp_q;
  assign o_frame_done  = fd_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Randomized scoreboard bench for seg_display_arbiter: a frame-level reference
// model queues the expected grant and digit patterns at each arbitration
// point; an independent monitor compares them as the display shows them.
module tb_seg_display_arbiter;
  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int HOLD    = 2;
  localparam int FRAME   = 8 * CLK_DIV + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] an;
  logic [6:0] a2g;
  logic       dp;
  logic       fd;

  seg_display_arbiter_if bus ();

  seg_display_arbiter #(
    .CLK_DIV(CLK_DIV),
    .BLANK_CYCLES(BLANK),
    .HOLD_FRAMES(HOLD)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus),
    .o_AN(an),
    .o_A2G(a2g),
    .o_DP(dp),
    .o_frame_done(fd)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } digit_t;

  digit_t     dq[$];
  logic [1:0] gq[$];

  logic [6:0] HEX [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one arbitration decision per frame, from the rules.
  initial begin
    int cur, hold, last, k;
    logic [1:0]  r;
    logic [31:0] word;
    logic [7:0]  mask;
    logic [3:0]  nib;
    cur = -1; hold = 0; last = 1; k = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        cur = -1; hold = 0; last = 1; k = 0;
        dq.delete();
        gq.delete();
      end else begin
        if (k == 0) begin
          r = bus.i_req;
          if (cur >= 0 && r[cur]) begin
            if (r[1-cur] && hold >= HOLD) begin
              cur = 1 - cur; hold = 1;
            end else if (hold < HOLD) begin
              hold++;
            end
          end else if (cur >= 0) begin
            if (r[1-cur]) begin cur = 1 - cur; hold = 1; end
            else begin cur = -1; hold = 0; end
          end else if (r == 2'b11) begin
            cur = 1 - last; hold = 1;
          end else if (r != 2'b00) begin
            cur = r[1] ? 1 : 0; hold = 1;
          end
          if (cur >= 0) last = cur;
          gq.push_back(cur < 0 ? 2'b00 : 2'(1 << cur));
          if (cur >= 0) begin
            word = (cur == 1) ? bus.i_data1 : bus.i_data0;
            mask = (cur == 1) ? bus.i_dp1 : bus.i_dp0;
            for (int d = 0; d < 8; d++) begin
              nib = word[4*d +: 4];
              dq.push_back('{an: ~(8'(1) << d), seg: HEX[nib], dp: ~mask[d]});
            end
          end
        end
        k = (k + 1) % FRAME;
      end
    end
  end

  // Monitor: compares each lit digit and each frame end against the queues.
  initial begin
    logic       prev_lit, lit;
    int         run, since_fd;
    digit_t     e;
    logic [15:0] run_val;
    prev_lit = 1'b0; run = 0; since_fd = -1; run_val = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_lit = 1'b0; run = 0; since_fd = -1;
        continue;
      end
      if (since_fd >= 0) since_fd++;
      lit = (an != 8'hFF);
      if (lit && !prev_lit) begin
        if (dq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_digit: got an=%h seg=%b expected blank at %0t", an, a2g, $time);
        end else begin
          e = dq.pop_front();
          check("digit_an", 32'(an), 32'(e.an));
          check("digit_seg", 32'(a2g), 32'(e.seg));
          check("digit_dp", 32'(dp), 32'(e.dp));
        end
        run = 1;
        run_val = {an, a2g, dp};
      end else if (lit) begin
        run++;
        check("digit_steady", 32'({an, a2g, dp}), 32'(run_val));
      end else if (prev_lit) begin
        check("digit_width", 32'(run), 32'(CLK_DIV - BLANK));
      end
      prev_lit = lit;
      if (fd) begin
        if (gq.size() == 0) begin
          tests++; fails++;
          $display("FAIL frame_grant: got %b expected no frame end at %0t", bus.o_grant, $time);
        end else begin
          check("frame_grant", 32'(bus.o_grant), 32'(gq.pop_front()));
        end
        if (since_fd >= 0) check("frame_period", 32'(since_fd), 32'(FRAME));
        since_fd = 0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
  endtask

  task automatic randomize_inputs();
    bus.i_req   = 2'($urandom_range(0, 3));
    bus.i_data0 = $urandom;
    bus.i_data1 = $urandom;
    bus.i_dp0   = 8'($urandom);
    bus.i_dp1   = 8'($urandom);
  endtask

  // Stimulus.
  initial begin
    int waited, split;
    bus.i_req = 2'b00; bus.i_data0 = '0; bus.i_data1 = '0;
    bus.i_dp0 = '0; bus.i_dp1 = '0;
    rst = 1'b1;
    cycles(3);
    check("reset_an", 32'(an), 32'hFF);
    check("reset_a2g", 32'(a2g), 32'h7F);
    check("reset_dp", 32'(dp), 32'h1);
    check("reset_grant", 32'(bus.o_grant), 32'h0);
    check("reset_frame_done", 32'(fd), 32'h0);

    // Zero word from requester 0: every digit shows 0.
    bus.i_req = 2'b01;
    rst = 1'b0;
    cycles(2 * FRAME);

    // Known word and DP mask.
    bus.i_data0 = 32'h89AB_CDEF;
    bus.i_dp0   = 8'h01;
    cycles(2 * FRAME);

    // Both requesting from reset: alternation every HOLD frames.
    do_reset();
    bus.i_req = 2'b11;
    for (int f = 0; f < 6; f++) begin
      bus.i_data0 = $urandom; bus.i_data1 = $urandom;
      bus.i_dp0 = 8'($urandom); bus.i_dp1 = 8'($urandom);
      cycles(FRAME);
    end

    // Data churning every cycle must only be seen at frame boundaries.
    bus.i_req = 2'b01;
    for (int c = 0; c < 3 * FRAME; c++) begin
      bus.i_data0 = $urandom;
      bus.i_dp0   = 8'($urandom);
      cycles(1);
    end

    // Request dropped: frame completes, then display stays dark.
    cycles(FRAME / 2);
    bus.i_req = 2'b00;
    cycles(3 * FRAME);

    // Random requests and data at random points within frames.
    for (int f = 0; f < 40; f++) begin
      split = $urandom_range(0, FRAME - 1);
      cycles(split);
      randomize_inputs();
      cycles(FRAME - split);
    end

    // Reset while digit 4 is being driven.
    bus.i_req = 2'b01;
    bus.i_data0 = $urandom;
    waited = 0;
    while (an !== 8'hEF && waited < 3 * FRAME) begin
      cycles(1);
      waited++;
    end
    if (an !== 8'hEF) begin
      tests++; fails++;
      $display("FAIL wait_digit4: got an=%h expected EF within %0d cycles", an, 3 * FRAME);
    end
    rst = 1'b1;
    cycles(1);
    check("midreset_an", 32'(an), 32'hFF);
    check("midreset_grant", 32'(bus.o_grant), 32'h0);
    cycles(2);
    rst = 1'b0;
    bus.i_req = 2'b11;
    for (int f = 0; f < 4; f++) begin
      bus.i_data0 = $urandom; bus.i_data1 = $urandom;
      cycles(FRAME);
    end
    cycles(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
